// File: rtl/mul_share_arb.sv
// Round-robin arbiter that time-shares one 8x8 multiplier among NREQ requesters.
// Each operation is IDLE (accept) -> MUL (multiply) -> RESP (hold until consumed).

module parallel_multiplier (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    // Carry recurrence written bit-serially; synthesis restructures it into lookahead form.
    function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        for (int i = 0; i < 15; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

    logic [15:0] pp  [8];
    logic [15:0] acc [8];

    for (genvar i = 0; i < 8; i++) begin : g_pp
        assign pp[i] = {8'b0, a_i & {8{b_i[i]}}} << i;
    end

    assign acc[0] = pp[0];
    for (genvar i = 1; i < 8; i++) begin : g_sum
        assign acc[i] = add16(acc[i-1], pp[i]);
    end

    assign p_o = acc[7];
endmodule

module mul_share_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t         state_q, state_d;
    logic [7:0]     op_a_q, op_b_q;
    logic [15:0]    res_q;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] last_grant_q;

    logic [15:0]    mul_p;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    logic           xfer;

    parallel_multiplier u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (mul_p)
    );

    // Scan from the far end back toward last_grant+1 so the nearest valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_grant_q) + k) % NREQ);
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign xfer = (state_q == IDLE) && gnt_found;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = MUL;
            MUL:     state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
            id_q         <= '0;
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (xfer) begin
                op_a_q       <= req_a[{gnt_idx, 3'b000} +: 8];
                op_b_q       <= req_b[{gnt_idx, 3'b000} +: 8];
                id_q         <= gnt_idx;
                last_grant_q <= gnt_idx;
            end
            if (state_q == MUL) begin
                res_q <= mul_p;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = res_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: table-driven single ops, scoreboard on responses,
// plus hand sequences for fairness, backpressure, reset mid-op and dropped requests.

module tb_mul_share_arb;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_ready;
    logic        busy;

    mul_share_arb #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] d;
    } rsp_t;

    vec_t vecs[8];
    rsp_t sb[$];
    int   n_cmp;
    int   n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Pushes every accepted request, pops and compares every consumed response.
    task automatic monitor();
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
            end else begin
                chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", {14'd0, rsp_id, rsp_data}, 32'hDEAD_0000);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_id", 32'(rsp_id), 32'(e.id));
                        chk("sb_data", 32'(rsp_data), 32'(e.d));
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e.id = 2'(i);
                        e.d  = 16'(req_a[i*8 +: 8]) * 16'(req_b[i*8 +: 8]);
                        sb.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic wait_grant(output logic [3:0] g);
        g = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 4'd0) begin
                g = req_ready;
                break;
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        logic [3:0] g;
        int         gid  [6];
        int         gcyc [6];
        int         ng;

        vecs[0] = '{2, 8'd200, 8'd150, 16'h7530};
        vecs[1] = '{0, 8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{0, 8'd0,   8'd173, 16'h0000};
        vecs[3] = '{0, 8'd1,   8'd255, 16'h00FF};
        vecs[4] = '{1, 8'd12,  8'd13,  16'h009C};
        vecs[5] = '{3, 8'd100, 8'd100, 16'h2710};
        vecs[6] = '{2, 8'd128, 8'd2,   16'h0100};
        vecs[7] = '{3, 8'd170, 8'd170, 16'h70E4};

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        fork
            monitor();
        join_none

        @(negedge clk);
        chk_zero_outputs("reset");
        #1 rst = 1'b0;

        // Single operations with latency and busy checks
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req_valid = 4'(1) << vecs[i].id;
            req_a[vecs[i].id*8 +: 8] = vecs[i].a;
            req_b[vecs[i].id*8 +: 8] = vecs[i].b;
            wait_grant(g);
            chk($sformatf("vec%0d_grant", i), 32'(g), 32'(4'(1) << vecs[i].id));
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_mul_busy", i), 32'(busy), 32'd1);
            chk($sformatf("vec%0d_mul_valid", i), 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].id));
            chk($sformatf("vec%0d_resp_busy", i), 32'(busy), 32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
        end

        // Round-robin fairness from a fresh reset
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(10 + 7 * i);
            req_b[i*8 +: 8] = 8'(20 + 3 * i);
        end
        req_valid = 4'b1111;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (req_ready != 4'd0) begin
                gcyc[ng] = c;
                gid[ng]  = -1;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gid[ng] = i;
                ng++;
            end
        end
        @(posedge clk); #1 req_valid = '0;
        chk("rr_count", 32'(ng), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < ng) begin
                chk($sformatf("rr_grant%0d", k), 32'(gid[k]), 32'(k % 4));
                if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd3);
            end
        end
        repeat (3) @(negedge clk);

        // Backpressure with requester 1 waiting
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a[7:0] = 8'd7;
        req_b[7:0] = 8'd9;
        wait_grant(g);
        chk("bp_grant0", 32'(g), 32'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_a[15:8] = 8'd11;
        req_b[15:8] = 8'd13;
        @(negedge clk);
        chk("bp_mul_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_data%0d", k), 32'(rsp_data), 32'd63);
            chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'd0);
            chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset while in MUL
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd6;
        wait_grant(g);
        chk("rmul_grant", 32'(g), 32'b0100);
        @(posedge clk); #1 req_valid = '0;
        #2;
        chk("rmul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1 chk_zero_outputs("rmul");
        @(negedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rmul_after_valid%0d", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("rmul_after_busy%0d", k), 32'(busy), 32'd0);
        end

        // Reset while in RESP
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[15:8] = 8'd9;
        req_b[15:8] = 8'd9;
        wait_grant(g);
        chk("rresp_grant", 32'(g), 32'b0010);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rresp_valid", 32'(rsp_valid), 32'd1);
        chk("rresp_data", 32'(rsp_data), 32'd81);
        #1 rst = 1'b1;
        #1 chk_zero_outputs("rresp");
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rresp_after_valid%0d", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("rresp_after_busy%0d", k), 32'(busy), 32'd0);
        end
        @(posedge clk); #1 req_valid = 4'b1111;
        wait_grant(g);
        chk("rresp_first_grant", 32'(g), 32'b0001);
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);

        // Requester 3 pulses req_valid only while the block is busy
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_a[7:0] = 8'd3;
        req_b[7:0] = 8'd4;
        wait_grant(g);
        chk("drop_grant0", 32'(g), 32'b0001);
        @(posedge clk); #1 req_valid = 4'b1000;
        @(negedge clk);
        chk("drop_mul_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("drop_resp_valid", 32'(rsp_valid), 32'd1);
        chk("drop_resp_data", 32'(rsp_data), 32'd12);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drop_idle_busy%0d", k), 32'(busy), 32'd0);
            chk($sformatf("drop_idle_ready%0d", k), 32'(req_ready), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
